// File: rtl/bridge_1xn_if.sv
// ---------------------------------------------------------------------------
// bridge_1xn_if
// Bus bundle for the 1-master / N-slave data bridge. It carries both sides
// of the bridge: the CPU data port (request in, read data out) and the
// per-slave request/response slices. It also carries the decode-error
// status and clear.
//
// Parameters
//   XLEN      data and address width
//   NSLV      number of slave ports
//   ERRCNT_W  width of the decode-error counter
//
// Modports
//   master : the system around the bridge (CPU plus slave memories). It
//            drives the CPU request, err_clr and the slave read data.
//   slave  : the bridge itself. It answers the CPU port, drives the slave
//            requests and reports decode errors.
// ---------------------------------------------------------------------------
interface bridge_1xn_if #(
    parameter int XLEN     = 32,
    parameter int NSLV     = 4,
    parameter int ERRCNT_W = 8
);
    // CPU data port
    logic                     cpu_data_en;
    logic [3:0]               cpu_data_wen;
    logic [XLEN-1:0]          cpu_data_addr;
    logic [XLEN-1:0]          cpu_data_wdata;
    logic [XLEN-1:0]          cpu_data_rdata;

    // Slave ports, slice i belongs to slave i
    logic [NSLV-1:0]          s_en;
    logic [4*NSLV-1:0]        s_wen;
    logic [XLEN*NSLV-1:0]     s_addr;
    logic [XLEN*NSLV-1:0]     s_wdata;
    logic [XLEN*NSLV-1:0]     s_rdata;

    // Decode-error status
    logic                     decerr;
    logic [ERRCNT_W-1:0]      err_cnt;
    logic [XLEN-1:0]          err_addr;
    logic                     err_clr;

    modport master (
        output cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata,
        output err_clr, s_rdata,
        input  cpu_data_rdata, s_en, s_wen, s_addr, s_wdata,
        input  decerr, err_cnt, err_addr
    );

    modport slave (
        input  cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata,
        input  err_clr, s_rdata,
        output cpu_data_rdata, s_en, s_wen, s_addr, s_wdata,
        output decerr, err_cnt, err_addr
    );
endinterface

// File: rtl/bridge_1xn.sv
// ---------------------------------------------------------------------------
// bridge_1xn
// Parametrised 1-master / N-slave data-bus bridge. The CPU data-port address
// is decoded against per-slave base/mask pairs. The request is forwarded
// combinationally to exactly one slave, and the lowest index wins on overlap.
// The selected slave's synchronous read data is returned one cycle later.
// Accesses that hit no region are unmapped. For those, writes are dropped,
// reads return DEF_RDATA, a one-cycle decerr pulse is raised, a saturating
// counter counts them, and the first such address is captured.
//
// Ports
//   clk    in  clock
//   reset  in  asynchronous, active-high reset
//   bus    bridge_1xn_if.slave:
//            cpu_data_en/wen/addr/wdata  in   CPU request (wen == 0 is a read)
//            cpu_data_rdata              out  read data, cycle after request
//            s_en/s_wen/s_addr/s_wdata   out  per-slave request slices
//            s_rdata                     in   per-slave one-cycle read data
//            decerr                      out  pulse the cycle after a miss
//            err_cnt                     out  saturating miss count
//            err_addr                    out  first miss address since clear
//            err_clr                     in   synchronous clear of error state
// ---------------------------------------------------------------------------
module bridge_1xn #(
    parameter int                     XLEN      = 32,
    parameter int                     NSLV      = 4,
    parameter logic [NSLV*XLEN-1:0]   SLV_BASE  = {NSLV{32'h0000_0000}},
    parameter logic [NSLV*XLEN-1:0]   SLV_MASK  = {NSLV{32'hFFFF_0000}},
    parameter logic [XLEN-1:0]        DEF_RDATA = 32'h0000_0000,
    parameter int                     ERRCNT_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    bridge_1xn_if.slave bus
);

    // ------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------
    logic [NSLV-1:0]     w_hit;        // raw region matches
    logic [NSLV-1:0]     w_win;        // one-hot winner (lowest hit)
    logic                w_miss;       // valid request that matched nothing
    logic [XLEN-1:0]     w_rd_or;      // OR of selected slave read data

    logic [NSLV-1:0]     r_sel;        // select of the last request
    logic                r_miss;       // last request was unmapped
    logic                r_decerr;     // decode-error pulse
    logic [ERRCNT_W-1:0] r_err_cnt;    // saturating miss counter
    logic [XLEN-1:0]     r_err_addr;   // first miss address
    logic                r_err_flag;   // first miss already captured

    // ------------------------------------------------------------------
    // Per-slave address match and request slices
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NSLV; g++) begin : g_slv
        // A region matches when the masked address equals the masked base.
        assign w_hit[g] = ((bus.cpu_data_addr & SLV_MASK[g*XLEN +: XLEN]) ==
                           (SLV_BASE[g*XLEN +: XLEN] & SLV_MASK[g*XLEN +: XLEN]));

        // Only the winning slice sees the byte enables. Address and data
        // are broadcast unmodified, so a slave whose s_en is low ignores them.
        assign bus.s_wen[g*4 +: 4]      = w_win[g] ? bus.cpu_data_wen : 4'b0000;
        assign bus.s_addr[g*XLEN +: XLEN]  = bus.cpu_data_addr;
        assign bus.s_wdata[g*XLEN +: XLEN] = bus.cpu_data_wdata;
    end

    // Priority pick: keep only the lowest-index hit so overlaps resolve deterministically
    always_comb begin
        logic v_found;
        w_win   = {NSLV{1'b0}};
        v_found = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (w_hit[i] && !v_found) begin
                w_win[i] = 1'b1;
                v_found  = 1'b1;
            end else begin
                w_win[i] = 1'b0;
            end
        end
    end

    // The request goes to no slave, so a write is dropped.
    assign w_miss  = bus.cpu_data_en & ~(|w_hit);

    // Enable is gated by request valid. The address may decode while the bus is idle.
    assign bus.s_en = {NSLV{bus.cpu_data_en}} & w_win;

    // ------------------------------------------------------------------
    // Response select
    // ------------------------------------------------------------------
    // Capture which slave (or the miss path) answers the next cycle; hold while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel  <= {NSLV{1'b0}};
            r_miss <= 1'b0;
        end else if (bus.cpu_data_en) begin
            r_sel  <= w_win;
            r_miss <= w_miss;
        end
    end

    // AND-OR read mux over the registered one-hot select
    always_comb begin
        w_rd_or = {XLEN{1'b0}};
        for (int i = 0; i < NSLV; i++) begin
            if (r_sel[i]) begin
                w_rd_or = w_rd_or | bus.s_rdata[i*XLEN +: XLEN];
            end else begin
                w_rd_or = w_rd_or;
            end
        end
    end

    // Slaves hold douta while not enabled. After reset r_sel is zero, so the
    // master sees 0 until its first request.
    assign bus.cpu_data_rdata = r_miss ? DEF_RDATA : w_rd_or;

    // ------------------------------------------------------------------
    // Decode-error bookkeeping
    // ------------------------------------------------------------------
    // One-cycle error pulse, registered every cycle regardless of err_clr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_decerr <= 1'b0;
        end else begin
            r_decerr <= w_miss;
        end
    end

    // Saturating miss counter and first-address capture. A clear wins over a
    // simultaneous miss, and that miss is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt  <= {ERRCNT_W{1'b0}};
            r_err_addr <= {XLEN{1'b0}};
            r_err_flag <= 1'b0;
        end else if (bus.err_clr) begin
            r_err_cnt  <= {ERRCNT_W{1'b0}};
            r_err_addr <= {XLEN{1'b0}};
            r_err_flag <= 1'b0;
        end else if (w_miss) begin
            if (r_err_cnt != {ERRCNT_W{1'b1}}) begin
                r_err_cnt <= r_err_cnt + ERRCNT_W'(1'b1);
            end
            if (!r_err_flag) begin
                r_err_addr <= bus.cpu_data_addr;
                r_err_flag <= 1'b1;
            end
        end
    end

    assign bus.decerr   = r_decerr;
    assign bus.err_cnt  = r_err_cnt;
    assign bus.err_addr = r_err_addr;

endmodule

// File: tb/tb_bridge_1xn.sv
// ---------------------------------------------------------------------------
// tb_bridge_1xn
// Directed bench for bridge_1xn using two instances.
//   dut_a : NSLV=3 map (S0 0x0000_0000/FFFF_0000, S1 0xBFAF_0000/FFFF_0000,
//           S2 0x1FC0_0000/FFF0_0000), ERRCNT_W=8, DEF_RDATA=0xDEAD_BEEF
//   dut_b : same map plus S3 overlapping S0, ERRCNT_W=2, DEF_RDATA=0
// ---------------------------------------------------------------------------
module tb_bridge_1xn;

    localparam logic [31:0] DEF_A = 32'hDEAD_BEEF;

    logic clk;
    logic reset;

    int n_tests;
    int n_fail;

    bridge_1xn_if #(.XLEN(32), .NSLV(3), .ERRCNT_W(8)) if_a ();
    bridge_1xn_if #(.XLEN(32), .NSLV(4), .ERRCNT_W(2)) if_b ();

    bridge_1xn #(
        .XLEN      (32),
        .NSLV      (3),
        .SLV_BASE  ({32'h1FC0_0000, 32'hBFAF_0000, 32'h0000_0000}),
        .SLV_MASK  ({32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
        .DEF_RDATA (DEF_A),
        .ERRCNT_W  (8)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    bridge_1xn #(
        .XLEN      (32),
        .NSLV      (4),
        .SLV_BASE  ({32'h0000_0000, 32'h1FC0_0000, 32'hBFAF_0000, 32'h0000_0000}),
        .SLV_MASK  ({32'hFFFF_0000, 32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
        .DEF_RDATA (32'h0000_0000),
        .ERRCNT_W  (2)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        reset = 1'b1;
        if_a.cpu_data_en = 1'b0; if_a.cpu_data_wen = 4'b0000;
        if_a.cpu_data_addr = 32'h0; if_a.cpu_data_wdata = 32'h0;
        if_a.err_clr = 1'b0;
        if_a.s_rdata = {32'h5555_5555, 32'h2222_2222, 32'h1111_1111};
        if_b.cpu_data_en = 1'b0; if_b.cpu_data_wen = 4'b0000;
        if_b.cpu_data_addr = 32'h0; if_b.cpu_data_wdata = 32'h0;
        if_b.err_clr = 1'b0;
        if_b.s_rdata = {32'h3B3B_3B3B, 32'h2B2B_2B2B, 32'h1B1B_1B1B, 32'h0A0A_0A0A};

        // ---- reset state ----
        cyc(); cyc();
        chk("rst_rdata",   {96'h0, if_a.cpu_data_rdata}, 128'h0);
        chk("rst_decerr",  {127'h0, if_a.decerr}, 128'h0);
        chk("rst_errcnt",  {120'h0, if_a.err_cnt}, 128'h0);
        chk("rst_erraddr", {96'h0, if_a.err_addr}, 128'h0);
        reset = 1'b0;
        cyc();

        // ---- back-to-back reads S0 then S1 ----
        if_a.cpu_data_en = 1'b1; if_a.cpu_data_addr = 32'h0000_0010;
        #1 chk("rd0_sen", {125'h0, if_a.s_en}, 128'h1);
        cyc();
        if_a.cpu_data_addr = 32'hBFAF_F000;
        #1 chk("rd1_sen", {125'h0, if_a.s_en}, 128'h2);
        chk("rd0_rdata", {96'h0, if_a.cpu_data_rdata}, 128'h1111_1111);
        cyc();
        if_a.cpu_data_en = 1'b0;
        #1 chk("rd1_rdata", {96'h0, if_a.cpu_data_rdata}, 128'h2222_2222);
        cyc();
        chk("idle_hold_rdata", {96'h0, if_a.cpu_data_rdata}, 128'h2222_2222);

        // ---- write to S2 ----
        if_a.cpu_data_en = 1'b1; if_a.cpu_data_wen = 4'b0011;
        if_a.cpu_data_addr = 32'h1FC0_0004; if_a.cpu_data_wdata = 32'hA5A5_5A5A;
        #1 chk("wr_sen",   {125'h0, if_a.s_en}, 128'h4);
        chk("wr_swen",     {116'h0, if_a.s_wen}, 128'h300);
        chk("wr_saddr",    {32'h0, if_a.s_addr}, {32'h0, {3{32'h1FC0_0004}}});
        chk("wr_swdata",   {32'h0, if_a.s_wdata}, {32'h0, {3{32'hA5A5_5A5A}}});
        cyc();
        if_a.cpu_data_wen = 4'b0000;

        // ---- first unmapped read ----
        if_a.cpu_data_addr = 32'h8000_0000;
        #1 chk("miss_sen", {125'h0, if_a.s_en}, 128'h0);
        chk("miss_swen",   {116'h0, if_a.s_wen}, 128'h0);
        cyc();
        if_a.cpu_data_en = 1'b0;
        #1 chk("miss_rdata", {96'h0, if_a.cpu_data_rdata}, {96'h0, DEF_A});
        chk("miss_decerr",   {127'h0, if_a.decerr}, 128'h1);
        chk("miss_errcnt",   {120'h0, if_a.err_cnt}, 128'h1);
        chk("miss_erraddr",  {96'h0, if_a.err_addr}, 128'h8000_0000);
        cyc();
        chk("decerr_pulse_end", {127'h0, if_a.decerr}, 128'h0);
        chk("miss_rdata_hold", {96'h0, if_a.cpu_data_rdata}, {96'h0, DEF_A});

        // ---- second miss: counter advances, address keeps first ----
        if_a.cpu_data_en = 1'b1; if_a.cpu_data_addr = 32'h9000_0000;
        cyc();
        if_a.cpu_data_en = 1'b0;
        #1 chk("miss2_errcnt", {120'h0, if_a.err_cnt}, 128'h2);
        chk("miss2_erraddr",   {96'h0, if_a.err_addr}, 128'h8000_0000);

        // ---- clear together with a miss ----
        if_a.cpu_data_en = 1'b1; if_a.err_clr = 1'b1; if_a.cpu_data_addr = 32'h9000_0000;
        cyc();
        if_a.cpu_data_en = 1'b0; if_a.err_clr = 1'b0;
        #1 chk("clr_errcnt", {120'h0, if_a.err_cnt}, 128'h0);
        chk("clr_erraddr",   {96'h0, if_a.err_addr}, 128'h0);
        chk("clr_decerr",    {127'h0, if_a.decerr}, 128'h1);

        // ---- capture re-arms after clear ----
        if_a.cpu_data_en = 1'b1; if_a.cpu_data_addr = 32'hA000_0000;
        cyc();
        if_a.cpu_data_en = 1'b0;
        #1 chk("rearm_errcnt", {120'h0, if_a.err_cnt}, 128'h1);
        chk("rearm_erraddr",   {96'h0, if_a.err_addr}, 128'hA000_0000);

        // ---- reset asserted mid-read ----
        if_a.cpu_data_en = 1'b1; if_a.cpu_data_addr = 32'hBFAF_0000;
        reset = 1'b1;
        #1 chk("rstmid_rdata", {96'h0, if_a.cpu_data_rdata}, 128'h0);
        chk("rstmid_sen",      {125'h0, if_a.s_en}, 128'h2);
        chk("rstmid_errcnt",   {120'h0, if_a.err_cnt}, 128'h0);
        cyc();
        reset = 1'b0; if_a.cpu_data_en = 1'b0;
        cyc();
        chk("postrst_rdata", {96'h0, if_a.cpu_data_rdata}, 128'h0);
        if_a.s_rdata = {32'h5555_5555, 32'h3333_3333, 32'h1111_1111};
        #1 chk("postrst_douta_chg", {96'h0, if_a.cpu_data_rdata}, 128'h0);

        // ---- dut_b: overlap resolves to lowest index ----
        if_b.cpu_data_en = 1'b1; if_b.cpu_data_addr = 32'h0000_0020;
        #1 chk("ovl_sen", {124'h0, if_b.s_en}, 128'h1);
        cyc();
        if_b.cpu_data_en = 1'b0;
        #1 chk("ovl_rdata", {96'h0, if_b.cpu_data_rdata}, 128'h0A0A_0A0A);

        // ---- dut_b: 2-bit counter saturates after 5 misses ----
        if_b.cpu_data_en = 1'b1; if_b.cpu_data_addr = 32'h8000_0000;
        cyc(); cyc();
        chk("sat_cnt2", {126'h0, if_b.err_cnt}, 128'h2);
        cyc(); cyc(); cyc();
        if_b.cpu_data_en = 1'b0;
        #1 chk("sat_cnt3", {126'h0, if_b.err_cnt}, 128'h3);
        chk("sat_decerr",  {127'h0, if_b.decerr}, 128'h1);
        chk("sat_rdata",   {96'h0, if_b.cpu_data_rdata}, 128'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bridge_1xn.md
Name: bridge_1xn

Overview:
- Parametrised 1-master / N-slave data-bus bridge for the SoC; successor to the fixed two-slave data bridge.
- Decodes the CPU data-port address against per-slave base/mask pairs and forwards each request to exactly one slave.
- Returns the selected slave's read data one cycle later, matching synchronous-SRAM read timing.
- Adds decode-error handling for unmapped accesses: default read data, dropped writes, an error pulse, a saturating error counter and a first-error address capture.

Parameters:
- XLEN, 32, data and address width.
- NSLV, 4, number of slave ports (1..16).
- SLV_BASE, {NSLV{32'h0}}, packed NSLV*XLEN vector; slice i is slave i's base address.
- SLV_MASK, {NSLV{32'hFFFF_0000}}, packed NSLV*XLEN vector; slice i is slave i's compare mask.
- DEF_RDATA, 32'h0, read data returned for unmapped reads.
- ERRCNT_W, 8, width of the decode-error counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- cpu_data_en  in  1  master request valid
- cpu_data_wen  in  4  master byte write enables (0 = read)
- cpu_data_addr  in  XLEN  master address
- cpu_data_wdata  in  XLEN  master write data
- cpu_data_rdata  out  XLEN  read data, valid the cycle after the request
- s_en  out  NSLV  per-slave enable
- s_wen  out  4*NSLV  per-slave byte write enables (slice i)
- s_addr  out  XLEN*NSLV  per-slave address (slice i)
- s_wdata  out  XLEN*NSLV  per-slave write data (slice i)
- s_rdata  in  XLEN*NSLV  per-slave read data (slice i), one-cycle synchronous
- decerr  out  1  one-cycle pulse, the cycle after an unmapped access
- err_cnt  out  ERRCNT_W  count of unmapped accesses, saturating
- err_addr  out  XLEN  address of the first unmapped access since reset or clear
- err_clr  in  1  synchronous clear of err_cnt, err_addr and the capture flag

Behaviour:
- Decode (combinational):
  - hit[i] = ((cpu_data_addr & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i])).
  - The lowest-index hit wins when regions overlap.
  - miss = cpu_data_en & ~|hit.
- Request forwarding (combinational, zero added latency):
  - s_en[i] = cpu_data_en & win[i].
  - s_wen[i] = win[i] ? cpu_data_wen : 0.
  - s_addr and s_wdata are broadcast unmodified to all slices. Slaves ignore them when their s_en is low.
  - Unmapped: every s_en and s_wen is 0, so writes are dropped.
- Response select (registered):
  - sel_q (one-hot NSLV) and miss_q are updated only on cycles with cpu_data_en=1; otherwise they hold.
  - cpu_data_rdata = miss_q ? DEF_RDATA : OR over i of (sel_q[i] ? s_rdata[i] : 0).
  - The slave holds its douta while not enabled, so rdata stays stable across idle cycles.
  - Writes also update sel_q; rdata after a write is don't-care for the master.
- Error logic:
  - decerr_q <= miss, registered every cycle; decerr = decerr_q.
  - On miss: err_cnt increments, saturating at all-ones. If the capture flag is 0, err_addr <= cpu_data_addr and the flag is set.
  - err_clr=1 zeroes err_cnt, err_addr and the flag. Clear takes priority over a simultaneous miss: the miss is not counted, but decerr still pulses.
- Reset values: sel_q=0, miss_q=0, decerr=0, err_cnt=0, err_addr=0, flag=0, cpu_data_rdata=0.
- Reset asserted mid-access: state clears immediately. While reset is high, s_en still follows the combinational decode; the master is held idle by its own reset.
- Back-to-back requests to different slaves: each response uses the select of its own request cycle. No bubbles; throughput is one access per cycle.
- NSLV=1: degenerate case; a single region plus the error path.

Test Plan:
- Map NSLV=3 as follows:
  - S0 base 0x0000_0000, mask 0xFFFF_0000.
  - S1 base 0xBFAF_0000, mask 0xFFFF_0000.
  - S2 base 0x1FC0_0000, mask 0xFFF0_0000.
- Read 0x0000_0010 then 0xBFAF_F000 on consecutive cycles, with S0 douta=0x1111_1111 and S1 douta=0x2222_2222 -> s_en = 3'b001 then 3'b010; cpu_data_rdata = 0x1111_1111 at cycle+1, 0x2222_2222 at cycle+2.
- Write wen=4'b0011 to 0x1FC0_0004 -> s_en[2]=1, s_wen slice 2 = 4'b0011, other slices 0.
- Read unmapped 0x8000_0000 -> all s_en=0; next cycle rdata=DEF_RDATA, decerr=1; err_cnt=1; err_addr=0x8000_0000.
- Second miss at 0x9000_0000 -> err_cnt=2, err_addr stays 0x8000_0000.
- err_clr together with a miss at 0x9000_0000 -> err_cnt=0, err_addr=0, decerr pulses.
- ERRCNT_W=2 with 5 misses -> err_cnt saturates at 3.
- Reset during a read, then idle with cpu_data_en=0 -> rdata=0; S1 douta changes to 0x3333_3333 -> rdata stays 0 (sel_q held at 0).
- Set S3 to overlap S0 with the same base and mask; read 0x0000_0020 -> only s_en[0]=1.
